// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
// csa_pkg : shared helpers for the pipelined carry-skip adder/subtractor
// Revision: 1.0
// ============================================================================
package csa_pkg;

    // Number of register slices; each slice covers BLK*BPS result bits.
    function automatic int nstg(input int width, input int blk, input int bps);
        return width / (blk * bps);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_blk.sv
`default_nettype none
// ============================================================================
// csa_blk : BLK-bit ripple block with group propagate for the skip mux
// Revision: 1.0
// ============================================================================
module csa_blk
    import csa_pkg::*;
#(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout,
    output logic           grp_p
);

    logic [BLK:0] c_rip;

    always_comb begin
        c_rip    = '0;
        sum      = '0;
        c_rip[0] = cin;
        for (int i = 0; i < BLK; i++) begin
            sum[i]     = a[i] ^ b[i] ^ c_rip[i];
            c_rip[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c_rip[i]);
        end
    end

    assign cout  = c_rip[BLK];
    assign grp_p = &(a ^ b);

endmodule
`default_nettype wire

// File: rtl/csa_pipe_adder.sv
`default_nettype none
// ============================================================================
// csa_pipe_adder : parametrised pipelined carry-skip adder/subtractor, valid/ready
// Revision: 1.0
// ============================================================================
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLK   = 4,
    parameter int BPS   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int SW   = BLK * BPS;
    localparam int NSTG = nstg(WIDTH, BLK, BPS);

    if (((WIDTH % SW) != 0) || (NSTG < 1)) begin : g_bad_cfg
        $error("csa_pipe_adder: WIDTH must be a non-zero multiple of BLK*BPS");
    end

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             c;
        logic             ovf;
    } pay_t;

    logic [NSTG-1:0] vld_q, vld_d, adv, vin;
    pay_t            pay_q   [NSTG];
    pay_t            pay_d   [NSTG];
    pay_t            stg_in  [NSTG];
    pay_t            stg_res [NSTG];

    // Advance chain runs from the output back to the input: in_ready never sees in_valid.
    always_comb begin
        adv           = '0;
        adv[NSTG-1]   = ~vld_q[NSTG-1] | out_ready;
        for (int k = NSTG - 2; k >= 0; k--) begin
            adv[k] = ~vld_q[k] | adv[k+1];
        end
    end

    assign in_ready = adv[0];

    always_comb begin
        vin       = '0;
        vin[0]    = in_valid;
        stg_in[0] = '{a:   in_a,
                      b:   in_sub ? ~in_b : in_b,
                      sum: '0,
                      c:   in_sub ? ~in_cin : in_cin,
                      ovf: 1'b0};
        for (int k = 1; k < NSTG; k++) begin
            vin[k]    = vld_q[k-1];
            stg_in[k] = pay_q[k-1];
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [WIDTH-1:0] op_a, op_b, sum_w;
        logic [SW-1:0]    blk_sum;

        assign op_a = stg_in[k].a;
        assign op_b = stg_in[k].b;

        for (genvar j = 0; j < BPS; j++) begin : g_blk
            localparam int LSB = (k * BPS + j) * BLK;
            logic cin_w, rc_out, grp_p, c_out;

            if (j == 0) begin : g_first
                assign cin_w = stg_in[k].c;
            end else begin : g_next
                assign cin_w = g_blk[j-1].c_out;
            end

            csa_blk #(.BLK(BLK)) u_blk (
                .a     (op_a[LSB +: BLK]),
                .b     (op_b[LSB +: BLK]),
                .cin   (cin_w),
                .sum   (blk_sum[j*BLK +: BLK]),
                .cout  (rc_out),
                .grp_p (grp_p)
            );

            assign c_out = rc_out | (grp_p & cin_w);
        end

        always_comb begin
            sum_w                = stg_in[k].sum;
            sum_w[k*SW +: SW]    = blk_sum;
        end

        // Carry into the slice MSB is recovered as a^b^sum; only the last slice's ovf is exported.
        assign stg_res[k] = '{a:   op_a,
                              b:   op_b,
                              sum: sum_w,
                              c:   g_blk[BPS-1].c_out,
                              ovf: op_a[k*SW+SW-1] ^ op_b[k*SW+SW-1] ^ blk_sum[SW-1]
                                   ^ g_blk[BPS-1].c_out};
    end

    always_comb begin
        vld_d = vld_q;
        for (int k = 0; k < NSTG; k++) begin
            pay_d[k] = pay_q[k];
            if (adv[k]) begin
                vld_d[k] = vin[k];
                if (vin[k]) begin
                    pay_d[k] = stg_res[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < NSTG; k++) begin
                pay_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < NSTG; k++) begin
                pay_q[k] <= pay_d[k];
            end
        end
    end

    assign out_valid = vld_q[NSTG-1];
    assign out_sum   = pay_q[NSTG-1].sum;
    assign out_cout  = pay_q[NSTG-1].c;
    assign out_ovf   = pay_q[NSTG-1].ovf;

    // Operand copies in the last slice and intermediate ovf bits are dead; synthesis trims them.
    logic unused_pay;
    always_comb begin
        unused_pay = 1'b0;
        for (int k = 0; k < NSTG; k++) begin
            unused_pay = unused_pay ^ (^pay_q[k]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csa_pipe_adder.sv
`default_nettype none
// ============================================================================
// tb_csa_pipe_adder : scoreboard bench for csa_pipe_adder (WIDTH=32, BLK=4, BPS=4)
// Revision: 1.0
// ============================================================================
module tb_csa_pipe_adder;

    localparam int W     = 32;
    localparam int NRAND = 10000;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic         in_cin    = 1'b0;
    logic         in_sub    = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W+1:0] sb [$];

    always #5 clk = ~clk;

    csa_pipe_adder #(.WIDTH(W), .BLK(4), .BPS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    // Reference: {sum, cout, ovf}
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] be;
        logic         c0;
        logic [W:0]   full;
        logic [W-1:0] low;
        be   = sub ? ~b : b;
        c0   = sub ? ~cin : cin;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c0};
        low  = {1'b0, a[W-2:0]} + {1'b0, be[W-2:0]} + {{(W-1){1'b0}}, c0};
        return {full[W-1:0], full[W], low[W-1] ^ full[W]};
    endfunction

    // Drives one op into an otherwise idle pipe and returns latency (negedges) and the result.
    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic sub, output int lat, output logic [W+1:0] got);
        int guard;
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        #1;
        while (!in_ready && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk); lat++;
        end
        got = {out_sum, out_cout, out_ovf};
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if ({out_sum, out_cout, out_ovf} !== '0)
            $display("FAIL reset_outputs: got %h/%b/%b want 0/0/0", out_sum, out_cout, out_ovf);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_add_wrap;
        int lat; logic [W+1:0] got;
        send_one(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, got);
        n_checks++;
        if (lat !== 2) $display("FAIL add_latency: got %0d want 2", lat);
        else n_pass++;
        n_checks++;
        if (got !== {32'h0000_0000, 1'b1, 1'b0})
            $display("FAIL add_wrap: got %h want %h", got, {32'h0000_0000, 1'b1, 1'b0});
        else n_pass++;
    endtask

    task automatic test_skip_chain;
        int lat; logic [W+1:0] got;
        send_one(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, lat, got);
        n_checks++;
        if (got !== {32'h0000_0000, 1'b1, 1'b0})
            $display("FAIL skip_chain: got %h want %h", got, {32'h0000_0000, 1'b1, 1'b0});
        else n_pass++;
        n_checks++;
        if (got !== model(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0))
            $display("FAIL skip_chain_model: got %h want %h", got, model(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0));
        else n_pass++;
    endtask

    task automatic test_sub_ovf;
        int lat; logic [W+1:0] got;
        send_one(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, lat, got);
        n_checks++;
        if (got !== {32'h8000_0000, 1'b0, 1'b1})
            $display("FAIL sub_ovf: got %h want %h", got, {32'h8000_0000, 1'b0, 1'b1});
        else n_pass++;
        send_one(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, lat, got);
        n_checks++;
        if (got !== {32'h0000_0001, 1'b1, 1'b0})
            $display("FAIL sub_borrow: got %h want %h", got, {32'h0000_0001, 1'b1, 1'b0});
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int idx, cyc, drained, stall_acc;
        logic [W+1:0] held, exp;
        logic held_ok, ir_stall;
        idx = 0; cyc = 0; drained = 0; stall_acc = 0; held_ok = 1'b0; held = '0; ir_stall = 1'bx;
        sb.delete();
        while ((idx < 8 || drained < 8) && cyc < 60) begin
            @(negedge clk);
            if (held_ok) begin
                n_checks++;
                if ({out_sum, out_cout, out_ovf} !== held)
                    $display("FAIL b2b_stall_stable: got %h want %h", {out_sum, out_cout, out_ovf}, held);
                else n_pass++;
            end
            in_valid  = (idx < 8);
            in_a      = 32'h1111_1111 * (idx + 1) + 32'hF;
            in_b      = 32'hF0F0_F0F0 ^ (idx * 32'h0101_0101);
            in_sub    = idx[0];
            in_cin    = idx[1];
            out_ready = (cyc >= 5);
            #1;
            if (cyc == 2) ir_stall = in_ready;
            if (in_valid && in_ready) begin
                sb.push_back(model(in_a, in_b, in_cin, in_sub));
                if (cyc < 5) stall_acc++;
                idx++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL b2b_extra_output: got %h want none", out_sum);
                end else begin
                    exp = sb.pop_front();
                    if ({out_sum, out_cout, out_ovf} !== exp)
                        $display("FAIL b2b_result: got %h want %h", {out_sum, out_cout, out_ovf}, exp);
                    else n_pass++;
                end
                drained++;
            end
            held_ok = out_valid && !out_ready;
            held    = {out_sum, out_cout, out_ovf};
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (stall_acc !== 2) $display("FAIL b2b_fill_count: got %0d want 2", stall_acc);
        else n_pass++;
        n_checks++;
        if (ir_stall !== 1'b0) $display("FAIL b2b_in_ready_stall: got %b want 0", ir_stall);
        else n_pass++;
        n_checks++;
        if (drained !== 8) $display("FAIL b2b_drained: got %0d want 8", drained);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int seen, lat; logic [W+1:0] got;
        sb.delete();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        in_a = 32'h1234_5678; in_b = 32'h1111_1111; in_cin = 1'b0; in_sub = 1'b0;
        @(negedge clk);
        in_a = 32'hDEAD_BEEF;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_sum !== '0) $display("FAIL midrst_out_sum: got %h want 0", out_sum);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL midrst_stale: got %0d outputs want 0", seen);
        else n_pass++;
        send_one(32'hCAFE_0000, 32'h0000_BABE, 1'b1, 1'b0, lat, got);
        n_checks++;
        if (got !== model(32'hCAFE_0000, 32'h0000_BABE, 1'b1, 1'b0) || lat !== 2)
            $display("FAIL midrst_new_op: got %h lat %0d want %h lat 2", got, lat,
                     model(32'hCAFE_0000, 32'h0000_BABE, 1'b1, 1'b0));
        else n_pass++;
    endtask

    task automatic test_random;
        int acc, drn, cyc;
        logic [W+1:0] exp;
        acc = 0; drn = 0; cyc = 0;
        sb.delete();
        while ((acc < NRAND || drn < acc) && cyc < 40000) begin
            @(negedge clk);
            in_valid  = (acc < NRAND) && ($urandom_range(0, 9) < 7);
            in_a      = $urandom;
            in_b      = ($urandom_range(0, 3) == 0) ? ~in_a : $urandom;
            in_cin    = 1'($urandom_range(0, 1));
            in_sub    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (in_valid && in_ready) begin
                sb.push_back(model(in_a, in_b, in_cin, in_sub));
                acc++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL rand_extra_output: got %h want none", out_sum);
                end else begin
                    exp = sb.pop_front();
                    if ({out_sum, out_cout, out_ovf} !== exp)
                        $display("FAIL rand_result: got %h want %h", {out_sum, out_cout, out_ovf}, exp);
                    else n_pass++;
                end
                drn++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (drn !== NRAND || acc !== NRAND)
            $display("FAIL rand_count: got acc %0d drained %0d want %0d", acc, drn, NRAND);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_add_wrap;
        test_skip_chain;
        test_sub_ovf;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
